// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control-word bubble pipeline: bundle layout,
// FSM state encoding and the all-zero bubble word.
// Imported by ctrl_stage_reg and ctrl_bubble_pipe.
package ctrl_pipe_pkg;

   localparam int CTRL_W_DEF = 12;

   // Control bundle field positions (MSB first).
   localparam int REG_WRITE_BIT  = 11;
   localparam int MEM_EN_BIT     = 10;
   localparam int MEM_RW_BIT     = 9;
   localparam int MEM_TO_REG_BIT = 8;
   localparam int ALU_SRC_BIT    = 7;
   localparam int STATUS_BIT     = 6;
   localparam int ALU_CTRL_MSB   = 5;
   localparam int ALU_CTRL_LSB   = 2;
   localparam int PC_SRC_BIT     = 1;
   localparam int MEM_SIZE_BIT   = 0;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_BUBBLE = 1'b1
   } bub_state_t;

   // A bubble carries no side effects: every enable bit is zero.
   localparam logic [CTRL_W_DEF-1:0] CTRL_ZERO = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One control pipeline stage register with valid bit; loads on !hold,
// flush squashes to zero/invalid and wins over hold.
// Latency: 1 cycle. Backpressure: hold freezes the stage contents.
// Ports: clk, reset (sync, active-high), hold, flush, d_word/d_valid in,
//        q_word/q_valid out.
module ctrl_stage_reg
   import ctrl_pipe_pkg::*;
#(
   parameter int W = CTRL_W_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         hold,
   input  logic         flush,
   input  logic [W-1:0] d_word,
   input  logic         d_valid,
   output logic [W-1:0] q_word,
   output logic         q_valid
);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         q_word  <= '0;
         q_valid <= 1'b0;
      end else if (!hold) begin
         // An invalid entry is stored as zero so it can never enable a write.
         q_word  <= d_valid ? d_word : '0;
         q_valid <= d_valid;
      end
   end

endmodule

// File: rtl/ctrl_bubble_pipe.sv
// Control-word pipeline ID/EX..MEM/WB with multi-cycle hazard bubble FSM,
// global stall, per-stage flush and per-stage valid tracking.
// Latency: stage k holds ctrl_in after k+1 unstalled edges. Backpressure:
// stall freezes all stages/FSM; decode_stall tells IF/ID to hold.
// Ports: clk, reset (sync, active-high), ctrl_in, in_valid, hazard_req,
//        hazard_cycles, stall, flush_mask -> ctrl_out, valid_out,
//        decode_stall, bubble_active [, bubble_count].
// Optional: CTRL_PIPE_BUBBLE_CNT_EN adds a saturating 32-bit bubble_count.
module ctrl_bubble_pipe
   import ctrl_pipe_pkg::*;
#(
   parameter int CTRL_W      = CTRL_W_DEF,
   parameter int STAGES      = 3,
   parameter int MAX_BUBBLES = 3,
   parameter int CNT_W       = $clog2(MAX_BUBBLES + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CTRL_W-1:0]        ctrl_in,
   input  logic                     in_valid,
   input  logic                     hazard_req,
   input  logic [CNT_W-1:0]         hazard_cycles,
   input  logic                     stall,
   input  logic [STAGES-1:0]        flush_mask,
   output logic [STAGES*CTRL_W-1:0] ctrl_out,
   output logic [STAGES-1:0]        valid_out,
   output logic                     decode_stall,
   output logic                     bubble_active
`ifdef CTRL_PIPE_BUBBLE_CNT_EN
   ,
   output logic [31:0]              bubble_count
`endif
);

   bub_state_t        state, state_nxt;
   logic [CNT_W-1:0]  bub_cnt, bub_cnt_nxt;
   logic [CNT_W-1:0]  eff_cnt;

   // Requested run length: 0 means one bubble, oversize requests clamp.
   always_comb begin
      eff_cnt = hazard_cycles;
      if (hazard_cycles == '0)
         eff_cnt = CNT_W'(1);
      else if (int'(hazard_cycles) > MAX_BUBBLES)
         eff_cnt = CNT_W'(MAX_BUBBLES);
   end

   // The IDLE cycle that accepts the request emits the first bubble, so the
   // counter only tracks the remaining eff_cnt-1 bubbles spent in BUBBLE.
   always_comb begin
      state_nxt   = state;
      bub_cnt_nxt = bub_cnt;
      if (flush_mask[0]) begin
         state_nxt   = ST_IDLE;
         bub_cnt_nxt = '0;
      end else if (!stall) begin
         case (state)
            ST_IDLE: begin
               if (hazard_req && (eff_cnt > CNT_W'(1))) begin
                  state_nxt   = ST_BUBBLE;
                  bub_cnt_nxt = eff_cnt - CNT_W'(1);
               end
            end
            ST_BUBBLE: begin
               if (bub_cnt <= CNT_W'(1)) begin
                  state_nxt   = ST_IDLE;
                  bub_cnt_nxt = '0;
               end else begin
                  bub_cnt_nxt = bub_cnt - CNT_W'(1);
               end
            end
            default: begin
               state_nxt   = ST_IDLE;
               bub_cnt_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         bub_cnt <= '0;
      end else begin
         state   <= state_nxt;
         bub_cnt <= bub_cnt_nxt;
      end
   end

   assign decode_stall  = ((state == ST_IDLE) && hazard_req) || (state == ST_BUBBLE);
   assign bubble_active = (state == ST_BUBBLE);

   logic [CTRL_W-1:0] stg_word [STAGES];
   logic [STAGES-1:0] stg_vld;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         // A decode stall turns the stage-0 intake into a bubble.
         ctrl_stage_reg #(.W(CTRL_W)) u_reg (
            .clk     (clk),
            .reset   (reset),
            .hold    (stall),
            .flush   (flush_mask[0]),
            .d_word  (ctrl_in),
            .d_valid (in_valid && !decode_stall),
            .q_word  (stg_word[0]),
            .q_valid (stg_vld[0])
         );
      end else begin : g_next
         ctrl_stage_reg #(.W(CTRL_W)) u_reg (
            .clk     (clk),
            .reset   (reset),
            .hold    (stall),
            .flush   (flush_mask[k]),
            .d_word  (stg_word[k-1]),
            .d_valid (stg_vld[k-1]),
            .q_word  (stg_word[k]),
            .q_valid (stg_vld[k])
         );
      end
      assign ctrl_out[k*CTRL_W +: CTRL_W] = stg_word[k];
   end

   assign valid_out = stg_vld;

`ifdef CTRL_PIPE_BUBBLE_CNT_EN
   // Only hazard bubbles that actually land in stage 0 are counted.
   logic bub_inject;
   assign bub_inject = decode_stall && !stall && !flush_mask[0];

   always_ff @(posedge clk) begin
      if (reset)
         bubble_count <= '0;
      else if (bub_inject && (bubble_count != '1))
         bubble_count <= bubble_count + 32'd1;
   end
`endif

endmodule
